// File: rtl/adsr_envelope_vca.sv
// ADSR envelope generator with a VCA stage: scales the signed oscillator sample
// by a saturating 16-bit envelope once per sample tick.
module adsr_envelope_vca #(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 16,
    parameter int TICK_DIV   = 512
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Gate,
    input  logic [ENV_WIDTH-1:0]  i_Attack_Inc,
    input  logic [ENV_WIDTH-1:0]  i_Decay_Dec,
    input  logic [ENV_WIDTH-1:0]  i_Sustain_Level,
    input  logic [ENV_WIDTH-1:0]  i_Release_Dec,
    input  logic [DATA_WIDTH-1:0] i_Sample,
    output logic [DATA_WIDTH-1:0] o_Sample,
    output logic                  o_Sample_Valid,
    output logic [ENV_WIDTH-1:0]  o_Env,
    output logic [2:0]            o_State,
    output logic                  o_Active
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = DATA_WIDTH + ENV_WIDTH;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX  = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] ENV_ZERO = {ENV_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ENV_WIDTH-1:0]    env_q, env_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    gate_q;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                    valid_q, valid_d;

    logic                    tick_s;
    logic                    rise_s;
    logic                    fall_s;
    logic [ENV_WIDTH:0]      sum_s;
    logic [ENV_WIDTH-1:0]    dec_diff_s;
    logic [ENV_WIDTH-1:0]    rel_diff_s;
    logic signed [PW-1:0]    sample_ext_s;
    logic signed [PW-1:0]    env_ext_s;
    logic signed [PW-1:0]    prod_s;
    logic                    unused_prod_s;

    assign tick_s       = (cnt_q == CW'(TICK_DIV - 1));
    assign rise_s       = i_Gate & ~gate_q;
    assign fall_s       = ~i_Gate & ((state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                                     (state_q == ST_SUSTAIN));
    assign sum_s        = {1'b0, env_q} + {1'b0, i_Attack_Inc};
    assign dec_diff_s   = env_q - i_Decay_Dec;
    assign rel_diff_s   = env_q - i_Release_Dec;
    // The envelope is zero-extended so the multiply treats it as a positive gain.
    assign sample_ext_s = {{ENV_WIDTH{i_Sample[DATA_WIDTH-1]}}, i_Sample};
    assign env_ext_s    = {{DATA_WIDTH{1'b0}}, env_q};
    assign prod_s       = sample_ext_s * env_ext_s;
    assign unused_prod_s = ^prod_s[ENV_WIDTH-1:0];

    // Next-state logic: gate events take priority over the per-tick envelope step.
    always_comb begin
        state_d  = state_q;
        env_d    = env_q;
        cnt_d    = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
        valid_d  = tick_s;
        sample_d = sample_q;
        if (tick_s) begin
            sample_d = prod_s[PW-1:ENV_WIDTH];
        end else begin
            sample_d = sample_q;
        end
        if (rise_s) begin
            state_d = ST_ATTACK;
        end else if (fall_s) begin
            state_d = ST_RELEASE;
        end else if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    env_d = ENV_ZERO;
                end
                ST_ATTACK: begin
                    if ((i_Attack_Inc == ENV_ZERO) || sum_s[ENV_WIDTH] ||
                        (sum_s[ENV_WIDTH-1:0] == ENV_MAX)) begin
                        env_d   = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = sum_s[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    // dec >= env saturates the difference to 0, which is always <= sustain
                    if ((i_Decay_Dec == ENV_ZERO) || (i_Decay_Dec >= env_q) ||
                        (dec_diff_s <= i_Sustain_Level)) begin
                        env_d   = i_Sustain_Level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = dec_diff_s;
                    end
                end
                ST_SUSTAIN: begin
                    env_d = i_Sustain_Level;
                end
                ST_RELEASE: begin
                    if ((i_Release_Dec == ENV_ZERO) || (i_Release_Dec >= env_q)) begin
                        env_d   = ENV_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = rel_diff_s;
                    end
                end
                default: begin
                    env_d   = ENV_ZERO;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            env_d = env_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            env_q    <= ENV_ZERO;
            cnt_q    <= {CW{1'b0}};
            gate_q   <= 1'b0;
            sample_q <= {DATA_WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            cnt_q    <= cnt_d;
            gate_q   <= i_Gate;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign o_Sample       = sample_q;
    assign o_Sample_Valid = valid_q;
    assign o_Env          = env_q;
    assign o_State        = state_q;
    assign o_Active       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_vca.sv
// Directed bench for adsr_envelope_vca with a 4-clock sample tick.
module tb_adsr_envelope_vca;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [15:0] attack_inc;
    logic [15:0] decay_dec;
    logic [15:0] sustain;
    logic [15:0] release_dec;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [15:0] env;
    logic [2:0]  state;
    logic        active;

    int vectors;
    int miscompares;

    adsr_envelope_vca #(.DATA_WIDTH(16), .ENV_WIDTH(16), .TICK_DIV(4)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Gate         (gate),
        .i_Attack_Inc   (attack_inc),
        .i_Decay_Dec    (decay_dec),
        .i_Sustain_Level(sustain),
        .i_Release_Dec  (release_dec),
        .i_Sample       (sample_in),
        .o_Sample       (sample_out),
        .o_Sample_Valid (sample_valid),
        .o_Env          (env),
        .o_State        (state),
        .o_Active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns on the falling edge right after a tick (o_Sample_Valid high).
    task automatic wait_tick(input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (!got) begin
                @(negedge clk);
                if (sample_valid === 1'b1) got = 1'b1;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s: no sample_valid within 8 clocks", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({env, state, sample_out, sample_valid, active} !== {16'h0, 3'd0, 16'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: env=%h state=%0d sample=%h valid=%b active=%b expected all 0",
                     env, state, sample_out, sample_valid, active);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (sample_valid !== ((k % 4) == 0)) begin
                miscompares++;
                $display("FAIL valid_period: clock %0d valid=%b expected %b", k, sample_valid, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_attack();
        logic [15:0] exp_env [4];
        logic [2:0]  exp_st  [4];
        logic [15:0] exp_smp [4];
        exp_env = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        exp_st  = '{3'd1, 3'd1, 3'd1, 3'd2};
        exp_smp = '{16'h0000, 16'h1FFF, 16'h3FFF, 16'h5FFE};
        attack_inc  = 16'h4000;
        decay_dec   = 16'h2000;
        sustain     = 16'h8000;
        release_dec = 16'h3000;
        sample_in   = 16'h7FFE;
        gate        = 1'b1;
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || env !== 16'h0000) begin
            miscompares++;
            $display("FAIL gate_rise: state=%0d env=%h expected 1 0000", state, env);
        end
        for (int i = 0; i < 4; i++) begin
            wait_tick("attack_tick");
            vectors++;
            if (env !== exp_env[i] || state !== exp_st[i] || sample_out !== exp_smp[i]) begin
                miscompares++;
                $display("FAIL attack_step%0d: env=%h state=%0d sample=%h expected %h %0d %h",
                         i, env, state, sample_out, exp_env[i], exp_st[i], exp_smp[i]);
            end
        end
    endtask

    task automatic test_decay();
        logic [15:0] exp_env [4];
        logic [2:0]  exp_st  [4];
        logic [15:0] exp_smp [4];
        exp_env = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h8000};
        exp_st  = '{3'd2, 3'd2, 3'd2, 3'd3};
        exp_smp = '{16'h8000, 16'h9000, 16'hA000, 16'hB000};
        sample_in = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            wait_tick("decay_tick");
            vectors++;
            if (env !== exp_env[i] || state !== exp_st[i] || sample_out !== exp_smp[i]) begin
                miscompares++;
                $display("FAIL decay_step%0d: env=%h state=%0d sample=%h expected %h %0d %h",
                         i, env, state, sample_out, exp_env[i], exp_st[i], exp_smp[i]);
            end
        end
        sustain = 16'h4000;
        wait_tick("sustain_tick");
        vectors++;
        if (env !== 16'h4000 || state !== 3'd3 || sample_out !== 16'hC000) begin
            miscompares++;
            $display("FAIL sustain_track: env=%h state=%0d sample=%h expected 4000 3 c000", env, state, sample_out);
        end
    endtask

    task automatic test_release();
        gate      = 1'b0;
        sample_in = 16'h7FFE;
        @(negedge clk);
        vectors++;
        if (state !== 3'd4 || env !== 16'h4000) begin
            miscompares++;
            $display("FAIL gate_fall: state=%0d env=%h expected 4 4000", state, env);
        end
        wait_tick("release_tick");
        vectors++;
        if (env !== 16'h1000 || state !== 3'd4) begin
            miscompares++;
            $display("FAIL release_step0: env=%h state=%0d expected 1000 4", env, state);
        end
        wait_tick("release_tick");
        vectors++;
        if (env !== 16'h0000 || state !== 3'd0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL release_end: env=%h state=%0d active=%b expected 0000 0 0", env, state, active);
        end
    endtask

    task automatic test_retrigger();
        attack_inc = 16'h6000;
        gate       = 1'b1;
        wait_tick("retrig_attack");
        vectors++;
        if (env !== 16'h6000 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL retrig_attack: env=%h state=%0d expected 6000 1", env, state);
        end
        gate = 1'b0;
        @(negedge clk);
        gate       = 1'b1;
        attack_inc = 16'h1000;
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || env !== 16'h6000) begin
            miscompares++;
            $display("FAIL retrig_rise: state=%0d env=%h expected 1 6000", state, env);
        end
        wait_tick("retrig_continue");
        vectors++;
        if (env !== 16'h7000 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL retrig_continue: env=%h state=%0d expected 7000 1", env, state);
        end
        // Gate changes land on the tick edge itself: state moves, envelope holds.
        repeat (3) @(negedge clk);
        gate = 1'b0;
        wait_tick("fall_on_tick");
        vectors++;
        if (env !== 16'h7000 || state !== 3'd4) begin
            miscompares++;
            $display("FAIL fall_on_tick: env=%h state=%0d expected 7000 4", env, state);
        end
        repeat (3) @(negedge clk);
        gate = 1'b1;
        wait_tick("rise_on_tick");
        vectors++;
        if (env !== 16'h7000 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL rise_on_tick: env=%h state=%0d expected 7000 1", env, state);
        end
    endtask

    task automatic test_zero_rates();
        attack_inc = 16'h0000;
        wait_tick("instant_attack");
        vectors++;
        if (env !== 16'hFFFF || state !== 3'd2) begin
            miscompares++;
            $display("FAIL instant_attack: env=%h state=%0d expected ffff 2", env, state);
        end
        decay_dec = 16'h0000;
        wait_tick("instant_decay");
        vectors++;
        if (env !== 16'h4000 || state !== 3'd3) begin
            miscompares++;
            $display("FAIL instant_decay: env=%h state=%0d expected 4000 3", env, state);
        end
        gate        = 1'b0;
        release_dec = 16'h0000;
        wait_tick("instant_release");
        vectors++;
        if (env !== 16'h0000 || state !== 3'd0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL instant_release: env=%h state=%0d active=%b expected 0000 0 0", env, state, active);
        end
    endtask

    task automatic test_reset_mid_note();
        attack_inc = 16'h4000;
        gate       = 1'b1;
        wait_tick("midnote_tick");
        wait_tick("midnote_tick");
        vectors++;
        if (env !== 16'h8000 || sample_out !== 16'h1FFF) begin
            miscompares++;
            $display("FAIL midnote_pre: env=%h sample=%h expected 8000 1fff", env, sample_out);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({env, state, sample_out, sample_valid, active} !== {16'h0, 3'd0, 16'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midnote_reset: env=%h state=%0d sample=%h valid=%b active=%b expected all 0",
                     env, state, sample_out, sample_valid, active);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || env !== 16'h0000) begin
            miscompares++;
            $display("FAIL gate_after_reset: state=%0d env=%h expected 1 0000", state, env);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        gate        = 1'b0;
        attack_inc  = 16'h0000;
        decay_dec   = 16'h0000;
        sustain     = 16'h0000;
        release_dec = 16'h0000;
        sample_in   = 16'h0000;
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_zero_rates();
        test_reset_mid_note();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
